// File: rtl/gemac_wb_pkg.sv
// Shared constants for the GEMAC wishbone register bank and its MDIO master.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package gemac_wb_pkg;

    // Wishbone byte offsets
    localparam logic [7:0] REG_MISC     = 8'h00;
    localparam logic [7:0] REG_UCAST_H  = 8'h04;
    localparam logic [7:0] REG_UCAST_L  = 8'h08;
    localparam logic [7:0] REG_MCAST_H  = 8'h0C;
    localparam logic [7:0] REG_MCAST_L  = 8'h10;
    localparam logic [7:0] REG_MDIO_CFG = 8'h14;
    localparam logic [7:0] REG_MIIADDR  = 8'h18;
    localparam logic [7:0] REG_MIIWDATA = 8'h1C;
    localparam logic [7:0] REG_MIICMD   = 8'h20;
    localparam logic [7:0] REG_MIISTAT  = 8'h24;
    localparam logic [7:0] REG_MIIRDATA = 8'h28;

    // Clause-22 frame fields
    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    // Preamble and frame lengths, in MDC periods
    localparam int MDIO_PRE_BITS      = 32;
    localparam int MDIO_FRAME_BITS    = 32;
    // On a read the master drives ST, OP, PHYAD and REGAD only
    localparam int MDIO_RD_DRIVE_BITS = 14;
    // Index of the first data bit inside the frame
    localparam int MDIO_DATA_FIRST    = 16;

    typedef enum logic [1:0] {
        MDIO_IDLE  = 2'd0,
        MDIO_PRE   = 2'd1,
        MDIO_FRAME = 2'd2,
        MDIO_DONE  = 2'd3
    } mdio_state_e;

    // 32-bit frame body, MSB sent first. The TA/data field of a read is
    // never driven, so its contents are irrelevant.
    function automatic logic [31:0] mdio_frame_word(input logic        is_rd,
                                                    input logic [4:0]  phyad,
                                                    input logic [4:0]  regad,
                                                    input logic [15:0] wdata);
        if (is_rd)
            return {MDIO_ST, MDIO_OP_RD, phyad, regad, 2'b11, 16'hFFFF};
        else
            return {MDIO_ST, MDIO_OP_WR, phyad, regad, MDIO_TA_WR, wdata};
    endfunction

endpackage

// File: rtl/gemac_wb_regs_if.sv
// Wishbone classic bus bundle between the control processor and the GEMAC regs.
// Latency: n/a (wires only).
// Backpressure: slave stretches cycles via wb_ack; master holds stb/cyc until ack.
// Ports: wb_stb/wb_cyc/wb_we/wb_adr/wb_dat_i from master, wb_dat_o/wb_ack from slave.
interface gemac_wb_regs_if #(parameter int ADDR_W = 8);
    logic              wb_stb;
    logic              wb_cyc;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_adr;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack;

    modport master (
        output wb_stb, wb_cyc, wb_we, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_stb, wb_cyc, wb_we, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack
    );
endinterface

// File: rtl/gemac_mdio_engine.sv
// Clause-22 MDIO master: divider, IDLE/PRE/FRAME/DONE sequencer, shift regs.
// Latency: 64 MDC periods per frame (32 with nopre) + 1 wb_clk for DONE.
// Backpressure: start is only honoured in IDLE; busy stays high until DONE retires.
// Ports: start/start_rd/nopre/div/phyad/regad/wdata in, mdc/mdio_o/mdio_oe/busy/rd_data out, mdio_i in.
module gemac_mdio_engine
    import gemac_wb_pkg::*;
#(
    parameter int DIV_MIN = 2
) (
    input  logic        wb_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        start_rd,
    input  logic        nopre,
    input  logic [7:0]  div,
    input  logic [4:0]  phyad,
    input  logic [4:0]  regad,
    input  logic [15:0] wdata,
    input  logic        mdio_i,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        busy,
    output logic [15:0] rd_data
);

    localparam logic [7:0] DIV_FLOOR = 8'(DIV_MIN);

    mdio_state_e state;
    logic [7:0]  half_q;
    logic [7:0]  div_cnt;
    logic [7:0]  half_nxt;
    logic [4:0]  bit_cnt;
    logic [31:0] frame_q;
    logic        is_rd;
    logic [15:0] rd_sh;
    logic        tick;
    logic        last_bit;
    logic        drive_nxt;

    // The half-period is re-latched at every boundary so that divider
    // changes made mid-frame apply from the next half-period on.
    assign half_nxt = (div < DIV_FLOOR) ? DIV_FLOOR : div;
    assign tick     = ({1'b0, div_cnt} + 9'd1) >= {1'b0, half_q};

    assign last_bit = (state == MDIO_PRE) ? (bit_cnt == 5'(MDIO_PRE_BITS - 1))
                                          : (bit_cnt == 5'(MDIO_FRAME_BITS - 1));

    // Whether the bit following the current one is driven by us
    assign drive_nxt = ~is_rd | ((bit_cnt + 5'd1) < 5'(MDIO_RD_DRIVE_BITS));

    always_ff @(posedge wb_clk or negedge reset) begin
        if (!reset) begin
            state   <= MDIO_IDLE;
            half_q  <= DIV_FLOOR;
            div_cnt <= '0;
            bit_cnt <= '0;
            frame_q <= '0;
            is_rd   <= 1'b0;
            rd_sh   <= '0;
            rd_data <= '0;
            mdc     <= 1'b0;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                MDIO_IDLE: begin
                    if (start) begin
                        // The start edge acts as the first MDC-low edge:
                        // bit 0 is presented here, first rise one half later.
                        half_q  <= half_nxt;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        mdc     <= 1'b0;
                        busy    <= 1'b1;
                        is_rd   <= start_rd;
                        frame_q <= mdio_frame_word(start_rd, phyad, regad, wdata);
                        mdio_oe <= 1'b1;
                        if (nopre) begin
                            state  <= MDIO_FRAME;
                            mdio_o <= MDIO_ST[1];
                        end else begin
                            state  <= MDIO_PRE;
                            mdio_o <= 1'b1;
                        end
                    end
                end

                MDIO_PRE, MDIO_FRAME: begin
                    if (tick) begin
                        div_cnt <= '0;
                        half_q  <= half_nxt;
                        if (!mdc) begin
                            mdc <= 1'b1;
                            if (state == MDIO_FRAME && is_rd &&
                                bit_cnt >= 5'(MDIO_DATA_FIRST))
                                rd_sh <= {rd_sh[14:0], mdio_i};
                        end else begin
                            mdc <= 1'b0;
                            if (last_bit) begin
                                bit_cnt <= '0;
                                if (state == MDIO_PRE) begin
                                    state   <= MDIO_FRAME;
                                    mdio_o  <= frame_q[31];
                                    mdio_oe <= 1'b1;
                                end else begin
                                    state   <= MDIO_DONE;
                                    mdio_o  <= 1'b1;
                                    mdio_oe <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                if (state == MDIO_FRAME) begin
                                    frame_q <= {frame_q[30:0], 1'b0};
                                    mdio_o  <= drive_nxt ? frame_q[30] : 1'b1;
                                    mdio_oe <= drive_nxt;
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                MDIO_DONE: begin
                    if (is_rd)
                        rd_data <= rd_sh;
                    busy  <= 1'b0;
                    state <= MDIO_IDLE;
                end

                default: state <= MDIO_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gemac_wb_regs.sv
// Wishbone slave register bank for the simple GEMAC plus MDIO management master.
// Latency: 1 wb_clk to wb_ack; writes land on the ack edge; read data valid with ack.
// Backpressure: none on wishbone; MIICMD writes while the MDIO engine is busy are dropped.
// Ports: wb (slave modport), misc_settings/ucast_addr/mcast_addr to the MAC, mdc/mdio_* to the PHY pad.
module gemac_wb_regs
    import gemac_wb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int MDIO_DIV_MIN = 2
) (
    input  logic           wb_clk,
    input  logic           reset,
    gemac_wb_regs_if.slave wb,
    output logic [6:0]     misc_settings,
    output logic [47:0]    ucast_addr,
    output logic [47:0]    mcast_addr,
    output logic           mdc,
    output logic           mdio_o,
    output logic           mdio_oe,
    input  logic           mdio_i
);

    logic [6:0]        misc_q;
    logic [15:0]       ucast_h_q;
    logic [31:0]       ucast_l_q;
    logic [15:0]       mcast_h_q;
    logic [31:0]       mcast_l_q;
    logic [7:0]        div_q;
    logic              nopre_q;
    logic [4:0]        phyad_q;
    logic [4:0]        regad_q;
    logic [15:0]       wdata_q;

    logic [ADDR_W-1:0] adr_b;
    logic              acc;
    logic              wr;
    logic [31:0]       rd_mux;
    logic              mdio_start;
    logic              mdio_busy;
    logic [15:0]       mdio_rdata;

    // Word-aligned byte address; the low two bits are don't-care.
    assign adr_b = wb.wb_adr & ~ADDR_W'(3);

    // One ack per sampled strobe, never two in a row.
    assign acc = wb.wb_stb & wb.wb_cyc & ~wb.wb_ack;
    assign wr  = acc & wb.wb_we;

    assign mdio_start = wr & (adr_b == ADDR_W'(REG_MIICMD)) &
                        (wb.wb_dat_i[0] | wb.wb_dat_i[1]) & ~mdio_busy;

    always_comb begin
        rd_mux = '0;
        case (adr_b)
            ADDR_W'(REG_MISC):     rd_mux = {25'd0, misc_q};
            ADDR_W'(REG_UCAST_H):  rd_mux = {16'd0, ucast_h_q};
            ADDR_W'(REG_UCAST_L):  rd_mux = ucast_l_q;
            ADDR_W'(REG_MCAST_H):  rd_mux = {16'd0, mcast_h_q};
            ADDR_W'(REG_MCAST_L):  rd_mux = mcast_l_q;
            ADDR_W'(REG_MDIO_CFG): rd_mux = {23'd0, nopre_q, div_q};
            ADDR_W'(REG_MIIADDR):  rd_mux = {19'd0, regad_q, 3'd0, phyad_q};
            ADDR_W'(REG_MIIWDATA): rd_mux = {16'd0, wdata_q};
            ADDR_W'(REG_MIISTAT):  rd_mux = {31'd0, mdio_busy};
            ADDR_W'(REG_MIIRDATA): rd_mux = {16'd0, mdio_rdata};
            default:               rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge reset) begin
        if (!reset) begin
            wb.wb_ack   <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            wb.wb_ack   <= acc;
            wb.wb_dat_o <= (acc & ~wb.wb_we) ? rd_mux : 32'd0;
        end
    end

    always_ff @(posedge wb_clk or negedge reset) begin
        if (!reset) begin
            misc_q    <= '0;
            ucast_h_q <= '0;
            ucast_l_q <= '0;
            mcast_h_q <= '0;
            mcast_l_q <= '0;
            div_q     <= '0;
            nopre_q   <= 1'b0;
            phyad_q   <= '0;
            regad_q   <= '0;
            wdata_q   <= '0;
        end else if (wr) begin
            case (adr_b)
                ADDR_W'(REG_MISC):     misc_q    <= wb.wb_dat_i[6:0];
                ADDR_W'(REG_UCAST_H):  ucast_h_q <= wb.wb_dat_i[15:0];
                ADDR_W'(REG_UCAST_L):  ucast_l_q <= wb.wb_dat_i;
                ADDR_W'(REG_MCAST_H):  mcast_h_q <= wb.wb_dat_i[15:0];
                ADDR_W'(REG_MCAST_L):  mcast_l_q <= wb.wb_dat_i;
                ADDR_W'(REG_MDIO_CFG): begin
                    div_q   <= wb.wb_dat_i[7:0];
                    nopre_q <= wb.wb_dat_i[8];
                end
                ADDR_W'(REG_MIIADDR): begin
                    phyad_q <= wb.wb_dat_i[4:0];
                    regad_q <= wb.wb_dat_i[12:8];
                end
                ADDR_W'(REG_MIIWDATA): wdata_q   <= wb.wb_dat_i[15:0];
                default: ;
            endcase
        end
    end

    assign misc_settings = misc_q;
    assign ucast_addr    = {ucast_h_q, ucast_l_q};
    assign mcast_addr    = {mcast_h_q, mcast_l_q};

    gemac_mdio_engine #(
        .DIV_MIN (MDIO_DIV_MIN)
    ) u_mdio (
        .wb_clk   (wb_clk),
        .reset    (reset),
        .start    (mdio_start),
        .start_rd (wb.wb_dat_i[0]),   // read wins when both command bits are set
        .nopre    (nopre_q),
        .div      (div_q),
        .phyad    (phyad_q),
        .regad    (regad_q),
        .wdata    (wdata_q),
        .mdio_i   (mdio_i),
        .mdc      (mdc),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
        .busy     (mdio_busy),
        .rd_data  (mdio_rdata)
    );

endmodule

// File: tb/tb_gemac_wb_regs.sv
// Directed bench for gemac_wb_regs: register map, ack timing, MDIO write/read frames, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_gemac_wb_regs;
    import gemac_wb_pkg::*;

    logic        wb_clk = 1'b0;
    logic        reset  = 1'b0;
    logic [6:0]  misc_settings;
    logic [47:0] ucast_addr;
    logic [47:0] mcast_addr;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b1;

    always #5 wb_clk = ~wb_clk;

    gemac_wb_regs_if #(.ADDR_W(8)) wb ();

    gemac_wb_regs #(.ADDR_W(8), .MDIO_DIV_MIN(2)) dut (
        .wb_clk        (wb_clk),
        .reset         (reset),
        .wb            (wb),
        .misc_settings (misc_settings),
        .ucast_addr    (ucast_addr),
        .mcast_addr    (mcast_addr),
        .mdc           (mdc),
        .mdio_o        (mdio_o),
        .mdio_oe       (mdio_oe),
        .mdio_i        (mdio_i)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // MDC-rise capture of what the master puts on the wire, plus a PHY model
    int          cap_n = 0;
    logic [63:0] cap_o = '0;
    logic [63:0] cap_oe = '0;
    longint      cap_t [0:63];
    int          phy_base = 0;
    logic [15:0] phy_word = '0;
    int          k;
    int          busy_cyc = 0;

    always @(posedge mdc) begin
        if (cap_n < 64) begin
            cap_o  = {cap_o[62:0], mdio_o};
            cap_oe = {cap_oe[62:0], mdio_oe};
            cap_t[cap_n] = $time;
        end
        cap_n++;
    end

    // Present the next data bit after each falling edge, ahead of the rise
    always @(negedge mdc) begin
        k = cap_n - phy_base - MDIO_DATA_FIRST;
        if (k >= 0 && k < 16) mdio_i = phy_word[15 - k];
        else                  mdio_i = 1'b1;
    end

    always @(negedge wb_clk) if (dut.mdio_busy === 1'b1) busy_cyc++;

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] din,
                           output logic [31:0] dout);
        int n;
        @(negedge wb_clk);
        wb.wb_stb = 1'b1; wb.wb_cyc = 1'b1; wb.wb_we = we;
        wb.wb_adr = adr;  wb.wb_dat_i = din;
        n = 0;
        do begin
            @(negedge wb_clk);
            n++;
        end while (wb.wb_ack !== 1'b1 && n < 8);
        check("wb_ack_seen", {63'd0, wb.wb_ack}, 64'd1);
        dout = wb.wb_dat_o;
        wb.wb_stb = 1'b0; wb.wb_cyc = 1'b0; wb.wb_we = 1'b0;
    endtask

    task automatic wb_wr(input logic [7:0] adr, input logic [31:0] din);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, din, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, adr, 32'd0, d);
        check(tag, {32'd0, d}, {32'd0, exp});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (dut.mdio_busy !== 1'b0 && n < budget) begin
            @(negedge wb_clk);
            n++;
        end
        check(tag, {63'd0, n < budget}, 64'd1);
    endtask

    task automatic arm_capture(input int base, input logic [15:0] word);
        cap_n = 0; cap_o = '0; cap_oe = '0;
        phy_base = base; phy_word = word; busy_cyc = 0;
    endtask

    logic [7:0] addrs [0:10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                                 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28};
    logic [3:0]  ack_pat;
    logic [63:0] exp_w;
    longint      t_ack;

    initial begin
        wb.wb_stb = 1'b0; wb.wb_cyc = 1'b0; wb.wb_we = 1'b0;
        wb.wb_adr = '0;   wb.wb_dat_i = '0;
        repeat (3) @(negedge wb_clk);
        check("rst_ack",     {63'd0, wb.wb_ack}, 64'd0);
        check("rst_dat_o",   {32'd0, wb.wb_dat_o}, 64'd0);
        check("rst_mdc",     {63'd0, mdc}, 64'd0);
        check("rst_mdio_o",  {63'd0, mdio_o}, 64'd1);
        check("rst_mdio_oe", {63'd0, mdio_oe}, 64'd0);
        reset = 1'b1;

        // Everything reads 0 out of reset
        for (int i = 0; i < 11; i++) rd_check($sformatf("rst_rd_%0h", addrs[i]), addrs[i], 32'd0);
        check("rst_misc", {57'd0, misc_settings}, 64'd0);

        // Settings registers
        wb_wr(8'h00, 32'h0000_003D);
        wb_wr(8'h04, 32'h0000_A0B0);
        wb_wr(8'h08, 32'hC0D0_A1B1);
        wb_wr(8'h0C, 32'h1234_5678);
        wb_wr(8'h10, 32'h9ABC_DEF0);
        check("misc_out",  {57'd0, misc_settings}, 64'h3D);
        check("ucast_out", {16'd0, ucast_addr}, 64'hA0B0_C0D0_A1B1);
        check("mcast_out", {16'd0, mcast_addr}, 64'h5678_9ABC_DEF0);
        rd_check("rd_misc",    8'h00, 32'h0000_003D);
        rd_check("rd_ucast_h", 8'h04, 32'h0000_A0B0);
        rd_check("rd_ucast_l", 8'h08, 32'hC0D0_A1B1);
        rd_check("rd_mcast_h", 8'h0E, 32'h0000_5678);   // low address bits ignored

        // Stretched strobe: ack every other cycle, repeat write is harmless
        @(negedge wb_clk);
        wb.wb_stb = 1'b1; wb.wb_cyc = 1'b1; wb.wb_we = 1'b1;
        wb.wb_adr = 8'h04; wb.wb_dat_i = 32'hFFFF_FFFF;
        ack_pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk);
            ack_pat = {ack_pat[2:0], wb.wb_ack};
        end
        wb.wb_stb = 1'b0; wb.wb_cyc = 1'b0; wb.wb_we = 1'b0;
        check("ack_hold_pattern", {60'd0, ack_pat}, 64'hA);
        rd_check("rd_ucast_h_ff", 8'h04, 32'h0000_FFFF);
        check("ucast_hi_ff", {48'd0, ucast_addr[47:32]}, 64'hFFFF);

        // Read-only / unmapped writes do nothing
        wb_wr(8'h28, 32'hDEAD_BEEF);
        wb_wr(8'h24, 32'hFFFF_FFFF);
        wb_wr(8'h30, 32'hFFFF_FFFF);
        rd_check("rd_miirdata_ro", 8'h28, 32'd0);
        rd_check("rd_miistat_ro",  8'h24, 32'd0);
        rd_check("rd_unmapped",    8'h30, 32'd0);

        // MDIO write, D=8, with preamble
        wb_wr(8'h14, 32'h0000_0008);
        wb_wr(8'h18, 32'h0000_0301);
        wb_wr(8'h1C, 32'h0000_1234);
        rd_check("rd_mdio_cfg", 8'h14, 32'h0000_0008);
        rd_check("rd_miiaddr",  8'h18, 32'h0000_0301);
        arm_capture(32, 16'h0000);
        wb_wr(8'h20, 32'h0000_0002);
        t_ack = $time - 5;                       // ack edge was half a cycle ago
        rd_check("miistat_busy", 8'h24, 32'd1);
        rd_check("rd_miicmd_0",  8'h20, 32'd0);
        wb_wr(8'h20, 32'h0000_0001);             // dropped: engine busy
        wait_idle("wr_frame_done", 3000);
        exp_w = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'h1234};
        check("wr_frame_bits", cap_o, exp_w);
        check("wr_frame_oe",   cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wr_mdc_count",  64'(cap_n), 64'd64);
        check("wr_first_rise", 64'(cap_t[0] - t_ack), 64'd80);
        check("wr_mdc_period", 64'(cap_t[1] - cap_t[0]), 64'd160);
        check("wr_mdc_period_end", 64'(cap_t[63] - cap_t[62]), 64'd160);
        check("wr_busy_cycles", 64'(busy_cyc), 64'(64 * 16 + 1));
        rd_check("miistat_idle", 8'h24, 32'd0);

        // MDIO read, nopre, both command bits set (read wins)
        wb_wr(8'h14, 32'h0000_0108);
        arm_capture(0, 16'hBEEF);
        wb_wr(8'h20, 32'h0000_0003);
        wait_idle("rd_frame_done", 3000);
        check("rd_frame_hdr",  {50'd0, cap_o[31:18]}, {50'd0, 2'b01, 2'b10, 5'd1, 5'd3});
        check("rd_frame_oe",   {32'd0, cap_oe[31:0]}, 64'hFFFC_0000);
        check("rd_mdc_count",  64'(cap_n), 64'd32);
        check("rd_busy_cycles", 64'(busy_cyc), 64'(32 * 16 + 1));
        check("rd_oe_after",   {63'd0, mdio_oe}, 64'd0);
        rd_check("miirdata_beef", 8'h28, 32'h0000_BEEF);

        // Reset in the middle of a read
        arm_capture(0, 16'h1111);
        wb_wr(8'h20, 32'h0000_0001);
        repeat (100) @(negedge wb_clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_mdc",     {63'd0, mdc}, 64'd0);
        check("abort_mdio_o",  {63'd0, mdio_o}, 64'd1);
        check("abort_mdio_oe", {63'd0, mdio_oe}, 64'd0);
        check("abort_misc",    {57'd0, misc_settings}, 64'd0);
        check("abort_ucast",   {16'd0, ucast_addr}, 64'd0);
        @(negedge wb_clk);
        reset = 1'b1;
        rd_check("abort_miirdata", 8'h28, 32'd0);
        rd_check("abort_miistat",  8'h24, 32'd0);
        rd_check("abort_cfg",      8'h14, 32'd0);

        // Default divider (floor of 2), preamble on, read completes normally
        wb_wr(8'h18, 32'h0000_0301);
        arm_capture(32, 16'h5A5A);
        wb_wr(8'h20, 32'h0000_0001);
        wait_idle("post_rst_done", 3000);
        check("post_rst_mdc_count",  64'(cap_n), 64'd64);
        check("post_rst_mdc_period", 64'(cap_t[1] - cap_t[0]), 64'd40);
        check("post_rst_busy",       64'(busy_cyc), 64'(64 * 4 + 1));
        rd_check("post_rst_miirdata", 8'h28, 32'h0000_5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
